// File: rtl/i2c_sensor_reader.sv
// I2C master that reads one 16-bit register from the greenhouse sensor at DEV_ADDR.
// Optional SCL clock stretching support is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_sensor_reader #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [6:0]  DEV_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic [15:0] data_out,
  input  logic        sda_in,
  input  logic        scl_in,
  output logic        sda_out,
  output logic        scl_out
);

  localparam int unsigned  QW        = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX     = QW'(CLK_DIV - 1);
  localparam logic [7:0]   ADDR_BYTE = {DEV_ADDR, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_RD_MSB, S_M_ACK, S_RD_LSB, S_M_NACK, S_STOP
  } state_t;

  state_t        r_state, w_next;
  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_quarter;
  logic [2:0]    r_bitcnt;
  logic [15:0]   r_shift;
  logic          r_sda_smp;
  logic          r_done;
  logic          r_ack_err;
  logic [15:0]   r_data;

  logic w_hold, w_q_end, w_slot_end, w_sample, w_byte_end, w_bit_state;

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave holding SCL low freezes the high quarters until the line actually rises.
  assign w_hold = ((r_quarter == 2'd1) || (r_quarter == 2'd2)) && scl_out && !scl_in;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_in;
  assign w_hold       = 1'b0;
`endif

  assign w_q_end     = (r_state != S_IDLE) && !w_hold && (r_qcnt == QMAX);
  assign w_slot_end  = w_q_end && (r_quarter == 2'd3);
  assign w_sample    = w_q_end && (r_quarter == 2'd2);
  assign w_byte_end  = w_slot_end && (r_bitcnt == 3'd7);
  assign w_bit_state = (r_state == S_ADDR) || (r_state == S_RD_MSB) || (r_state == S_RD_LSB);

  assign done     = r_done;
  assign ack_err  = r_ack_err;
  assign data_out = r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start)      w_next = S_START;
      S_START:    if (w_slot_end) w_next = S_ADDR;
      S_ADDR:     if (w_byte_end) w_next = S_ADDR_ACK;
      S_ADDR_ACK: if (w_slot_end) w_next = r_sda_smp ? S_STOP : S_RD_MSB;
      S_RD_MSB:   if (w_byte_end) w_next = S_M_ACK;
      S_M_ACK:    if (w_slot_end) w_next = S_RD_LSB;
      S_RD_LSB:   if (w_byte_end) w_next = S_M_NACK;
      S_M_NACK:   if (w_slot_end) w_next = S_STOP;
      S_STOP:     if (w_slot_end) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    sda_out = 1'b1;
    scl_out = 1'b1;
    case (r_state)
      S_IDLE: ;
      S_START: begin
        sda_out = (r_quarter == 2'd0);
        scl_out = (r_quarter != 2'd3);
      end
      S_STOP: begin
        sda_out = r_quarter[1];
        scl_out = (r_quarter != 2'd0);
      end
      default: begin
        scl_out = (r_quarter == 2'd1) || (r_quarter == 2'd2);
        if (r_state == S_ADDR)       sda_out = ADDR_BYTE[~r_bitcnt];
        else if (r_state == S_M_ACK) sda_out = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_qcnt    <= '0;
      r_quarter <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_sda_smp <= 1'b1;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_data    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_qcnt    <= '0;
        r_quarter <= '0;
        r_bitcnt  <= '0;
        if (start) r_ack_err <= 1'b0;
      end else if (!w_hold) begin
        r_qcnt <= (r_qcnt == QMAX) ? '0 : r_qcnt + 1'b1;
        if (r_qcnt == QMAX) r_quarter <= r_quarter + 1'b1;
      end
      if (w_sample) begin
        r_sda_smp <= sda_in;
        if ((r_state == S_RD_MSB) || (r_state == S_RD_LSB)) r_shift <= {r_shift[14:0], sda_in};
      end
      if (w_slot_end && w_bit_state) r_bitcnt <= r_bitcnt + 1'b1;
      if (w_slot_end && (r_state == S_ADDR_ACK) && r_sda_smp) r_ack_err <= 1'b1;
      if (w_slot_end && (r_state == S_STOP)) begin
        r_done <= 1'b1;
        if (!r_ack_err) r_data <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_i2c_sensor_reader.sv
// Scoreboard bench for i2c_sensor_reader with an open-drain sensor slave model at 7'h48.
module tb_i2c_sensor_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, ack_err, sda_out, scl_out;
  logic [15:0] data_out;
  logic        sda_line, scl_line;

  logic        slave_sda = 1'b1;
  logic        slave_scl = 1'b1;
  logic [15:0] slave_word = 16'h0000;
  logic        slave_ack = 1'b1;
  logic        slave_stretch = 1'b0;

  assign sda_line = sda_out & slave_sda;
  assign scl_line = scl_out & slave_scl;

  i2c_sensor_reader #(.CLK_DIV(4), .DEV_ADDR(7'h48)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .ack_err(ack_err),
    .data_out(data_out), .sda_in(sda_line), .scl_in(scl_line), .sda_out(sda_out), .scl_out(scl_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  typedef enum int {P_IDLE, P_ADDR, P_AACK, P_TX, P_MACK} sph_t;
  sph_t        ph = P_IDLE;
  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  int unsigned bitn = 0, byte_idx = 0, str_cnt = 0;
  int unsigned start_cnt = 0, stop_cnt = 0;
  logic [7:0]  shreg = '0, addr_seen = '0;
  logic [1:0]  mack = 2'b01;

  always @(negedge clk) begin
    logic s_scl, s_sda;
    logic [7:0] b;
    s_scl = scl_line;
    s_sda = sda_line;
    b = (byte_idx == 0) ? slave_word[15:8] : slave_word[7:0];
    if (str_cnt != 0) begin
      str_cnt--;
      if (str_cnt == 0) slave_scl = 1'b1;
    end
    if (prev_scl && s_scl && prev_sda && !s_sda) begin
      start_cnt++; ph = P_ADDR; bitn = 0; shreg = '0; addr_seen = '0; mack = 2'b01; slave_sda = 1'b1;
    end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
      stop_cnt++; ph = P_IDLE; slave_sda = 1'b1;
    end else if (!prev_scl && s_scl) begin
      case (ph)
        P_ADDR: begin shreg = {shreg[6:0], s_sda}; bitn++; end
        P_TX:   bitn++;
        P_MACK: mack[byte_idx] = s_sda;
        default: ;
      endcase
    end else if (prev_scl && !s_scl) begin
      case (ph)
        P_ADDR: if (bitn == 8) begin
          addr_seen = shreg;
          if (slave_ack && shreg == 8'h91) begin slave_sda = 1'b0; ph = P_AACK; end
          else ph = P_IDLE;
        end
        P_AACK: begin
          ph = P_TX; byte_idx = 0; bitn = 0; slave_sda = slave_word[15];
          // 28 low cycles: 8 of the master's own SCL-low time plus 20 of stretch
          if (slave_stretch) begin slave_scl = 1'b0; str_cnt = 28; slave_stretch = 1'b0; end
        end
        P_TX: if (bitn == 8) begin slave_sda = 1'b1; ph = P_MACK; end
              else slave_sda = b[7 - bitn];
        P_MACK: if (byte_idx == 0) begin
          byte_idx = 1; bitn = 0; ph = P_TX; slave_sda = slave_word[7];
        end else ph = P_IDLE;
        default: ;
      endcase
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [15:0] data;
    logic        aerr;
    int unsigned lat;
    int unsigned t0;
    logic        chk_data;
    logic        chk_mack;
  } exp_t;
  exp_t        sb[$];
  exp_t        me;
  logic        prev_done = 1'b0;
  int unsigned done_cnt = 0;

  always @(negedge clk) begin
    if (prev_done) chk("done_single_cycle", done, 1'b0);
    prev_done = done;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no transaction (cycle %0d)", cyc);
      end else begin
        me = sb.pop_front();
        chk("busy_at_done", busy, 1'b0);
        chk("ack_err", ack_err, me.aerr);
        chk("latency", cyc - me.t0, me.lat);
        chk("addr_byte", addr_seen, 8'h91);
        if (me.chk_data) chk("data_out", data_out, me.data);
        if (me.chk_mack) chk("master_ack_nack", mack, 2'b10);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [15:0] word, input logic ack, input logic [15:0] edata,
                       input logic eaerr, input int unsigned lat, input logic cdata, input logic cmack);
    exp_t e;
    slave_word = word;
    slave_ack  = ack;
    e.data = edata; e.aerr = eaerr; e.lat = lat; e.t0 = cyc; e.chk_data = cdata; e.chk_mack = cmack;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL done_timeout: got no done, expected done within 3000 cycles (cycle %0d)", cyc);
  endtask

  initial begin
    int unsigned sc0, dc0, pc0;
    repeat (3) @(negedge clk);
    chk("rst_sda_out", sda_out, 1'b1);
    chk("rst_scl_out", scl_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_data_out", data_out, 16'h0000);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // successful read
    issue(16'h1980, 1'b1, 16'h1980, 1'b0, 465, 1'b1, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);

    // address NACK: data_out keeps 16'h1980
    issue(16'hBEEF, 1'b0, 16'h1980, 1'b1, 177, 1'b1, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    chk("ack_err_held", ack_err, 1'b1);
    chk("data_kept_after_nack", data_out, 16'h1980);

    // start while busy is ignored
    sc0 = start_cnt; dc0 = done_cnt;
    issue(16'h3C21, 1'b1, 16'h3C21, 1'b0, 465, 1'b1, 1'b1);
    repeat (49) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    chk("start_conditions", start_cnt - sc0, 1);
    chk("done_pulses", done_cnt - dc0, 1);

    // back-to-back: second start in the done cycle
    issue(16'h1980, 1'b1, 16'h1980, 1'b0, 465, 1'b1, 1'b1);
    wait_done();
    issue(16'h0A5F, 1'b1, 16'h0A5F, 1'b0, 465, 1'b1, 1'b1);
    chk("busy_b2b", busy, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);

    // reset mid-ADDR, 50 cycles after start
    slave_ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("busy_mid_addr", busy, 1'b1);
    pc0 = stop_cnt;
    rst = 1'b0;
    #1;
    chk("midrst_sda_out", sda_out, 1'b1);
    chk("midrst_scl_out", scl_out, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_data_out", data_out, 16'h0000);
    repeat (3) @(negedge clk);
    chk("midrst_no_stop", stop_cnt - pc0, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // clock stretch of 20 cycles in the first RD_MSB bit
    slave_stretch = 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
    issue(16'h1980, 1'b1, 16'h1980, 1'b0, 485, 1'b1, 1'b1);
`else
    issue(16'h1980, 1'b1, 16'h1980, 1'b0, 465, 1'b0, 1'b0);
`endif
    wait_done();
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_sensor_reader.md
Name: i2c_sensor_reader

Overview:
- I2C master that reads one 16-bit register from the greenhouse temperature/humidity sensor.
- Drives the open-drain pad controls `sda_out`/`scl_out` and samples `sda_in`/`scl_in` from the bidirectional pads: 0 = pad pulls low, 1 = pad released.
- Started by the main control FSM. Returns the sensor word, which feeds the control logic and the 7-segment display path.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period; legal values are 2 and above.
- DEV_ADDR, 7'h48, 7-bit I2C slave address of the sensor.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin one read transaction
- busy  output  1  high from the cycle after `start` is accepted until `done`
- done  output  1  single-cycle pulse when the transaction ends
- ack_err  output  1  address NACK seen in the last transaction; valid when `done` is high, held until the next accepted start
- data_out  output  16  {MSB byte, LSB byte} of the last successful read
- sda_in  input  1  SDA level from the pad
- scl_in  input  1  SCL level from the pad
- sda_out  output  1  SDA drive control (0 = pull low, 1 = release)
- scl_out  output  1  SCL drive control (0 = pull low, 1 = release)

Behaviour:
- Reset values (`rst` = 0, asynchronous): sda_out = 1, scl_out = 1, busy = 0, done = 0, ack_err = 0, data_out = 16'h0000, FSM in IDLE.
- Reset mid-transaction: both lines released immediately, no STOP is generated, `data_out` returns to 0.
- Timing unit: a quarter-tick counter counts 0..CLK_DIV-1 and runs only when not IDLE. Each bus "slot" is 4 quarters, q0..q3.
- Start acceptance: `start` sampled high in IDLE moves the FSM to START on the next edge, busy = 1, ack_err cleared. `start` while busy is ignored.
- START slot: q0 SDA=1 SCL=1; q1 SDA=0 SCL=1; q2 SDA=0 SCL=1; q3 SDA=0 SCL=0.
- Bit slot:
  - q0 SCL=0, SDA set to the bit being sent (or released when receiving).
  - q1 and q2 SCL=1.
  - `sda_in` is sampled on the last clk of q2.
  - q3 SCL=0.
  - SDA changes only in q0.
- STOP slot: q0 SDA=0 SCL=0; q1 SDA=0 SCL=1; q2 SDA=1 SCL=1; q3 SDA=1 SCL=1.
- FSM sequence: IDLE -> START -> ADDR -> ADDR_ACK -> RD_MSB -> M_ACK -> RD_LSB -> M_NACK -> STOP -> IDLE.
  - ADDR: 8 slots sending {DEV_ADDR, 1'b1}, MSB first.
  - ADDR_ACK: 1 slot, SDA released. Sampled 0 = ACK. Sampled 1 = NACK: set ack_err = 1 and jump to STOP.
  - RD_MSB: 8 slots, SDA released; the sampled bits shift MSB first into a shift register.
  - M_ACK: 1 slot, master drives SDA = 0.
  - RD_LSB: 8 slots, as RD_MSB.
  - M_NACK: 1 slot, master releases SDA = 1.
  - STOP: 1 slot.
- Bit counter: 3 bits, wraps 7 -> 0 at each byte boundary.
- Completion: on the clk edge ending STOP q3:
  - busy = 0 and done = 1 for exactly one cycle.
  - `data_out` is updated only if ack_err = 0.
  - The FSM enters IDLE and can accept a new `start` in the cycle `done` is high.
- Latency (no stretching), measured from the edge that samples `start` to the cycle `done` is high:
  - Success: 29 slots, i.e. 116*CLK_DIV + 1 cycles.
  - Address NACK: 11 slots, i.e. 44*CLK_DIV + 1 cycles.
- No multi-master arbitration. The slave's data-phase ACK behaviour is not checked.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined:
  - In q1 and q2 of bit, STOP and START slots, if scl_out = 1 but `scl_in` = 0, the quarter counter holds.
  - Sampling and SCL-low transitions are delayed until `scl_in` reads 1, so latency grows by the stretched cycles.
- Undefined: `scl_in` is ignored and timing is fixed as above.

Test Plan:
- Reset: assert rst=0 mid-ADDR with CLK_DIV=4 -> sda_out=1, scl_out=1, busy=0, data_out=0 within the same cycle; no STOP pattern on the bus.
- Successful read: slave model at 7'h48 ACKs, returns 8'h19 then 8'h80 -> address byte on bus = 8'h91, master ACK after the first byte, NACK after the second, data_out=16'h1980, ack_err=0, done pulse at start+465 cycles (CLK_DIV=4).
- Address NACK: no slave responds -> ack_err=1, STOP follows directly after the ACK slot, done at start+177 cycles, data_out keeps its previous value 16'h1980.
- Start while busy: pulse `start` again 50 cycles into a transaction -> ignored, exactly one START condition and one done pulse.
- Back-to-back: assert `start` in the cycle done=1 -> second transaction starts; busy drops for at most 1 cycle; second read of 16'h0A5F returns correctly.
- Clock stretch (I2C_CLOCK_STRETCH_EN): slave holds scl_in=0 for 20 cycles in the first RD_MSB bit -> data still 16'h1980, done delayed by 20 cycles; with the macro undefined, the same stimulus gives fixed 465-cycle timing.
